sample_feeder: RTL and testbench
================================

// Module: sample_feeder
// PURPOSE
//  Training-sample source sitting directly upstream of the perceptron neuron.
//  - Buffers (x1, x2, t) samples written by a host and reports the sample count on nInput.
//  - Serves one sample per requestFlag through the requestFlag/dataReady handshake.
//  - Wraps to sample 0 after the last sample, so the neuron can run repeated epochs until it asserts done.
// PARAMETERS
//  DEPTH   64  max samples held
//  ADDR_W  6   pointer width, clog2(DEPTH)
//  X_W     7   width of x1/x2 (two's complement)
//  T_W     2   width of target t
//  N_W     32  width of nInput count
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  clear        in   1      sync: empty buffer, return to LOAD
//  wrEn         in   1      host write strobe (LOAD state only)
//  wrX1         in   X_W    sample x1
//  wrX2         in   X_W    sample x2
//  wrT          in   T_W    sample target
//  loadDone     in   1      host pulse: buffer complete, begin serving
//  requestFlag  in   1      neuron asks for next sample
//  nInput       out  N_W    frozen sample count (0 until loadDone accepted)
//  x1Input      out  X_W    served x1, held until next serve
//  x2Input      out  X_W    served x2
//  tInput       out  T_W    served t
//  dataReady    out  1      one-cycle pulse: x1/x2/t valid
//  lastSample   out  1      high with dataReady when served index == count-1
//  overflow     out  1      sticky: write attempted while full
//  emptyErr     out  1      one-cycle pulse: loadDone with count==0
// BEHAVIOUR
//  Reset: every output 0; state LOAD; wrPtr, rdPtr, count = 0; overflow cleared.
//  States: LOAD -> READY -> FETCH -> PRESENT -> READY.
//  LOAD:
//   - wrEn with count<DEPTH: mem[wrPtr] <= {wrX1,wrX2,wrT}; wrPtr++, count++.
//   - wrEn with count==DEPTH: write dropped; overflow <= 1.
//   - loadDone with count>0: nInput <= count (zero-extended), rdPtr <= 0, go READY.
//   - loadDone with count==0: emptyErr pulses, stay in LOAD.
//   - wrEn and loadDone in the same cycle: write first; count includes it.
//   - requestFlag ignored.
//  READY: requestFlag==1 -> issue sync read of mem[rdPtr], go FETCH.
//  FETCH: capture read data into the output registers, go PRESENT.
//  PRESENT:
//   - dataReady=1 for exactly this cycle; lastSample=(rdPtr==count-1).
//   - rdPtr <= (rdPtr==count-1) ? 0 : rdPtr+1; go READY.
//  Latency: requestFlag sampled at edge k -> dataReady high in cycle k+2.
//   Max rate is one sample per 3 cycles.
//  requestFlag while in FETCH/PRESENT is ignored (not queued).
//   A requester holding it high gets back-to-back serves at 3-cycle spacing.
//  wrEn/loadDone outside LOAD: ignored; nInput stays frozen.
//  clear (any state): synchronous to LOAD.
//   - Pointers, count, nInput, overflow -> 0; dataReady forced 0 that cycle.
//   - Data outputs hold their last values.
//  Async rst mid-FETCH/PRESENT: dataReady drops immediately; no sample served.
//  count width ADDR_W+1, so DEPTH itself is representable.
//  No arithmetic on sample data; fields pass through bit-exact.
// STRUCTURE
//  Package feeder_pkg:
//   - state enum {LOAD, READY, FETCH, PRESENT}.
//   - Width localparams X_W, T_W, N_W; SAMPLE_W = 2*X_W+T_W.
//  Sub-module sample_mem:
//   - DEPTH x SAMPLE_W, one sync write port, one sync read port (1-cycle read).
//   - No reset on array contents.
//  Top holds the FSM, pointers, count, and output registers.
// TESTING
//  1 Reset: assert rst mid-run -> all outputs 0 same cycle, state LOAD, nInput=0.
//  2 Basic serve:
//     - Write (5,-3,1),(10,2,0),(-64,63,3); pulse loadDone -> nInput=3.
//     - requestFlag at k -> dataReady at k+2 with x1=5, x2=-3, t=1, lastSample=0.
//  3 Wrap: continue from 2 with 3 more requests -> samples 1, 2 (lastSample=1), then sample 0 again.
//  4 Overflow: DEPTH+1 writes -> count=DEPTH, overflow=1; last write absent on serve.
//  5 Ignored requests:
//     - requestFlag in LOAD -> no dataReady.
//     - requestFlag held high -> dataReady exactly every 3 cycles, no skipped index.
//  6 Edge cases:
//     - loadDone with 0 writes -> emptyErr one pulse, stays LOAD.
//     - clear in PRESENT -> dataReady 0 that cycle, nInput=0.

Source files
------------

// File: rtl/sample_feeder_pkg.sv
// ---------------------------------------------------------------------------
// feeder_pkg
// Shared widths and the FSM state type for the sample_feeder block.
//   DEPTH    : samples the buffer can hold
//   ADDR_W   : pointer width, clog2(DEPTH)
//   X_W/T_W  : widths of the x1/x2 features and the target t
//   N_W      : width of the reported sample count
//   SAMPLE_W : packed {x1, x2, t} width stored per buffer entry
// ---------------------------------------------------------------------------
package feeder_pkg;
  localparam int DEPTH    = 64;
  localparam int ADDR_W   = 6;
  localparam int X_W      = 7;
  localparam int T_W      = 2;
  localparam int N_W      = 32;
  localparam int SAMPLE_W = 2 * X_W + T_W;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    READY   = 2'd1,
    FETCH   = 2'd2,
    PRESENT = 2'd3
  } state_e;
endpackage

// File: rtl/sample_feeder_if.sv
// ---------------------------------------------------------------------------
// sample_feeder_if
// Bundles the host load port and the neuron request port of sample_feeder.
//   master : host + neuron side (drives clear/wr*/loadDone/requestFlag)
//   slave  : the feeder (drives nInput, served sample, status flags)
//
// Handshake: the neuron raises requestFlag while the feeder is idle in
// READY; the request is taken on that rising edge and two edges later
// dataReady is high for exactly one cycle with x1Input/x2Input/tInput
// valid (they then hold until the next serve). A request seen while a
// serve is in flight is dropped, not queued; holding requestFlag high
// yields one serve every three cycles.
// ---------------------------------------------------------------------------
interface sample_feeder_if;
  import feeder_pkg::*;

  logic           clear;
  logic           wrEn;
  logic [X_W-1:0] wrX1;
  logic [X_W-1:0] wrX2;
  logic [T_W-1:0] wrT;
  logic           loadDone;
  logic           requestFlag;

  logic [N_W-1:0] nInput;
  logic [X_W-1:0] x1Input;
  logic [X_W-1:0] x2Input;
  logic [T_W-1:0] tInput;
  logic           dataReady;
  logic           lastSample;
  logic           overflow;
  logic           emptyErr;

  modport master (
    output clear, wrEn, wrX1, wrX2, wrT, loadDone, requestFlag,
    input  nInput, x1Input, x2Input, tInput, dataReady, lastSample,
           overflow, emptyErr
  );

  modport slave (
    input  clear, wrEn, wrX1, wrX2, wrT, loadDone, requestFlag,
    output nInput, x1Input, x2Input, tInput, dataReady, lastSample,
           overflow, emptyErr
  );
endinterface

// File: rtl/sample_feeder_mem.sv
// ---------------------------------------------------------------------------
// sample_mem
// Simple dual-port sample buffer: one synchronous write port and one
// synchronous read port with one cycle of read latency. Contents are not
// reset; only entries written during LOAD are ever read back.
//   i_clk      : clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_en    : read strobe (o_rd_data updates on the next edge)
//   i_rd_addr  : read address
//   o_rd_data  : registered read data
// ---------------------------------------------------------------------------
module sample_mem #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int W      = 16
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [W-1:0]      i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [W-1:0]      o_rd_data
);
  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/sample_feeder.sv
// ---------------------------------------------------------------------------
// sample_feeder
// Training-sample source for the perceptron neuron. The host loads
// (x1, x2, t) samples, then pulses loadDone; the feeder freezes the count
// on nInput and serves one sample per requestFlag, wrapping back to
// sample 0 after the last one so the neuron can run repeated epochs.
//   clk, rst    : clock, asynchronous active-high reset
//   bus (slave) : host load port, neuron request port, status flags
//   o_dbg_state : current FSM state, for observation only
// ---------------------------------------------------------------------------
module sample_feeder
  import feeder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  sample_feeder_if.slave        bus,
  output state_e                o_dbg_state
);
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] ZERO_COUNT = '0;

  state_e              r_state;
  state_e              w_next_state;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     w_count_after;
  logic [N_W-1:0]      r_n_input;
  logic [X_W-1:0]      r_x1;
  logic [X_W-1:0]      r_x2;
  logic [T_W-1:0]      r_t;
  logic                r_overflow;
  logic                r_empty_err;
  logic                w_in_load;
  logic                w_full;
  logic                w_write;
  logic                w_drop;
  logic                w_load_ok;
  logic                w_load_empty;
  logic                w_at_last;
  logic                w_rd_en;
  logic                w_data_ready;
  logic                w_last_sample;
  logic [SAMPLE_W-1:0] w_rd_data;

  // Load-side decode. clear overrides everything in the cycle it is seen.
  assign w_in_load     = (r_state == LOAD);
  assign w_full        = (r_count == FULL_COUNT);
  assign w_write       = w_in_load && bus.wrEn && !w_full && !bus.clear;
  assign w_drop        = w_in_load && bus.wrEn &&  w_full && !bus.clear;
  // A write coinciding with loadDone is counted before the count freezes.
  assign w_count_after = r_count + (w_write ? ONE_COUNT : ZERO_COUNT);
  assign w_load_ok     = w_in_load && bus.loadDone && !bus.clear &&
                         (w_count_after != ZERO_COUNT);
  assign w_load_empty  = w_in_load && bus.loadDone && !bus.clear &&
                         (w_count_after == ZERO_COUNT);
  assign w_at_last     = ({1'b0, r_rd_ptr} == (r_count - ONE_COUNT));

  sample_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (SAMPLE_W)
  ) u_mem (
    .i_clk     (clk),
    .i_wr_en   (w_write),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({bus.wrX1, bus.wrX2, bus.wrT}),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    if (bus.clear) begin
      w_next_state = LOAD;
    end else begin
      case (r_state)
        LOAD:    if (w_load_ok) w_next_state = READY;
        READY:   if (bus.requestFlag) w_next_state = FETCH;
        FETCH:   w_next_state = PRESENT;
        PRESENT: w_next_state = READY;
        default: w_next_state = LOAD;
      endcase
    end
  end

  // FSM: outputs. dataReady is decoded from the state register so an async
  // reset or a clear in PRESENT removes it within the same cycle.
  always_comb begin
    w_rd_en       = 1'b0;
    w_data_ready  = 1'b0;
    w_last_sample = 1'b0;
    if (!bus.clear) begin
      w_rd_en       = (r_state == READY) && bus.requestFlag;
      w_data_ready  = (r_state == PRESENT);
      w_last_sample = (r_state == PRESENT) && w_at_last;
    end
  end

  // Pointers, count, frozen count, flags and served-sample registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_n_input   <= '0;
      r_overflow  <= 1'b0;
      r_empty_err <= 1'b0;
      r_x1        <= '0;
      r_x2        <= '0;
      r_t         <= '0;
    end else if (bus.clear) begin
      // Served data deliberately holds across clear.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_n_input   <= '0;
      r_overflow  <= 1'b0;
      r_empty_err <= 1'b0;
    end else begin
      r_empty_err <= w_load_empty;
      r_count     <= w_count_after;
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_drop)  r_overflow <= 1'b1;
      if (w_load_ok) begin
        r_n_input <= N_W'(w_count_after);
        r_rd_ptr  <= '0;
      end
      if (r_state == FETCH) begin
        r_x1 <= w_rd_data[SAMPLE_W-1 -: X_W];
        r_x2 <= w_rd_data[T_W+X_W-1 -: X_W];
        r_t  <= w_rd_data[T_W-1:0];
      end
      if (r_state == PRESENT) begin
        r_rd_ptr <= w_at_last ? '0 : r_rd_ptr + 1'b1;
      end
    end
  end

  assign bus.nInput     = r_n_input;
  assign bus.x1Input    = r_x1;
  assign bus.x2Input    = r_x2;
  assign bus.tInput     = r_t;
  assign bus.dataReady  = w_data_ready;
  assign bus.lastSample = w_last_sample;
  assign bus.overflow   = r_overflow;
  assign bus.emptyErr   = r_empty_err;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_sample_feeder.sv
// ---------------------------------------------------------------------------
// tb_sample_feeder
// Directed bench for sample_feeder: reset, basic serve, wrap, overflow,
// ignored requests / held request, empty load and clear-in-PRESENT.
// ---------------------------------------------------------------------------
module tb_sample_feeder;
  import feeder_pkg::*;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     n_vec;
  int     n_err;

  sample_feeder_if bus_if ();

  sample_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic write_sample(input logic [X_W-1:0] x1, input logic [X_W-1:0] x2,
                              input logic [T_W-1:0] t);
    bus_if.wrEn = 1'b1;
    bus_if.wrX1 = x1;
    bus_if.wrX2 = x2;
    bus_if.wrT  = t;
    tick();
    bus_if.wrEn = 1'b0;
  endtask

  task automatic load_done();
    bus_if.loadDone = 1'b1;
    tick();
    bus_if.loadDone = 1'b0;
  endtask

  task automatic do_clear();
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
  endtask

  // One request pulse; waits (bounded) for dataReady and returns the edges
  // taken plus the served fields, then lets the FSM return to READY.
  task automatic request_sample(output int lat, output logic [X_W-1:0] x1,
                                output logic [X_W-1:0] x2, output logic [T_W-1:0] t,
                                output logic last);
    bus_if.requestFlag = 1'b1;
    tick();
    bus_if.requestFlag = 1'b0;
    lat = 1;
    while (!bus_if.dataReady && lat < 8) begin
      tick();
      lat++;
    end
    x1   = bus_if.x1Input;
    x2   = bus_if.x2Input;
    t    = bus_if.tInput;
    last = bus_if.lastSample;
    tick();
  endtask

  task automatic test_reset();
    bus_if.clear = 0; bus_if.wrEn = 0; bus_if.wrX1 = 0; bus_if.wrX2 = 0;
    bus_if.wrT = 0; bus_if.loadDone = 0; bus_if.requestFlag = 0;
    rst = 1'b1;
    tick(); tick();
    n_vec++;
    if ({bus_if.dataReady, bus_if.lastSample, bus_if.overflow, bus_if.emptyErr} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000",
        {bus_if.dataReady, bus_if.lastSample, bus_if.overflow, bus_if.emptyErr});
    end
    n_vec++;
    if ({bus_if.nInput, bus_if.x1Input, bus_if.x2Input, bus_if.tInput} !== '0) begin
      n_err++; $display("FAIL reset_data: nInput=%0d x1=%h x2=%h t=%h want all 0",
        bus_if.nInput, bus_if.x1Input, bus_if.x2Input, bus_if.tInput);
    end
    n_vec++;
    if (dbg_state !== LOAD) begin
      n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, LOAD);
    end
    rst = 1'b0;
    tick();
    // Mid-run reset while in PRESENT.
    write_sample(7'h11, 7'h22, 2'd2);
    load_done();
    bus_if.requestFlag = 1'b1;
    tick();
    bus_if.requestFlag = 1'b0;
    tick();
    n_vec++;
    if (bus_if.dataReady !== 1'b1 || bus_if.x1Input !== 7'h11) begin
      n_err++; $display("FAIL reset_pre_serve: dataReady=%b x1=%h want 1/11",
        bus_if.dataReady, bus_if.x1Input);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus_if.dataReady !== 1'b0 || bus_if.lastSample !== 1'b0 || bus_if.x1Input !== 7'h00) begin
      n_err++; $display("FAIL reset_midrun_outputs: dataReady=%b last=%b x1=%h want 0/0/00",
        bus_if.dataReady, bus_if.lastSample, bus_if.x1Input);
    end
    n_vec++;
    if (dbg_state !== LOAD || bus_if.nInput !== 32'd0) begin
      n_err++; $display("FAIL reset_midrun_state: state=%0d nInput=%0d want 0/0",
        dbg_state, bus_if.nInput);
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_serve();
    int lat; logic [X_W-1:0] x1, x2; logic [T_W-1:0] t; logic last;
    write_sample(7'h05, 7'h7D, 2'd1);   // ( 5, -3, 1)
    write_sample(7'h0A, 7'h02, 2'd0);   // (10,  2, 0)
    write_sample(7'h40, 7'h3F, 2'd3);   // (-64, 63, 3)
    n_vec++;
    if (bus_if.nInput !== 32'd0) begin
      n_err++; $display("FAIL basic_ninput_before_load: got %0d want 0", bus_if.nInput);
    end
    load_done();
    n_vec++;
    if (bus_if.nInput !== 32'd3 || dbg_state !== READY) begin
      n_err++; $display("FAIL basic_ninput: nInput=%0d state=%0d want 3/%0d",
        bus_if.nInput, dbg_state, READY);
    end
    request_sample(lat, x1, x2, t, last);
    n_vec++;
    if (lat !== 2) begin
      n_err++; $display("FAIL basic_latency: got %0d edges want 2", lat);
    end
    n_vec++;
    if ({x1, x2, t, last} !== {7'h05, 7'h7D, 2'd1, 1'b0}) begin
      n_err++; $display("FAIL basic_sample0: x1=%h x2=%h t=%0d last=%b want 05/7d/1/0",
        x1, x2, t, last);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [X_W-1:0] x1, x2; logic [T_W-1:0] t; logic last;
    request_sample(lat, x1, x2, t, last);
    n_vec++;
    if ({x1, x2, t, last} !== {7'h0A, 7'h02, 2'd0, 1'b0} || lat !== 2) begin
      n_err++; $display("FAIL wrap_sample1: x1=%h x2=%h t=%0d last=%b lat=%0d want 0a/02/0/0/2",
        x1, x2, t, last, lat);
    end
    request_sample(lat, x1, x2, t, last);
    n_vec++;
    if ({x1, x2, t, last} !== {7'h40, 7'h3F, 2'd3, 1'b1} || lat !== 2) begin
      n_err++; $display("FAIL wrap_sample2: x1=%h x2=%h t=%0d last=%b lat=%0d want 40/3f/3/1/2",
        x1, x2, t, last, lat);
    end
    request_sample(lat, x1, x2, t, last);
    n_vec++;
    if ({x1, x2, t, last} !== {7'h05, 7'h7D, 2'd1, 1'b0} || lat !== 2) begin
      n_err++; $display("FAIL wrap_sample0: x1=%h x2=%h t=%0d last=%b lat=%0d want 05/7d/1/0/2",
        x1, x2, t, last, lat);
    end
  endtask

  task automatic test_overflow();
    int lat; logic [X_W-1:0] x1, x2; logic [T_W-1:0] t; logic last;
    logic [X_W-1:0] ei;
    int bad;
    do_clear();
    n_vec++;
    if (bus_if.nInput !== 32'd0 || bus_if.overflow !== 1'b0 || dbg_state !== LOAD) begin
      n_err++; $display("FAIL ovf_after_clear: nInput=%0d ovf=%b state=%0d want 0/0/0",
        bus_if.nInput, bus_if.overflow, dbg_state);
    end
    for (int i = 0; i < DEPTH; i++) begin
      ei = X_W'(i);
      write_sample(ei, ~ei, ei[1:0]);
    end
    n_vec++;
    if (bus_if.overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_at_full: overflow=%b want 0", bus_if.overflow);
    end
    write_sample(7'h55, 7'h2A, 2'd2);
    n_vec++;
    if (bus_if.overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_set: overflow=%b want 1", bus_if.overflow);
    end
    load_done();
    n_vec++;
    if (bus_if.nInput !== 32'd64 || bus_if.overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_ninput: nInput=%0d ovf=%b want 64/1",
        bus_if.nInput, bus_if.overflow);
    end
    bad = 0;
    for (int j = 0; j < DEPTH; j++) begin
      ei = X_W'(j);
      request_sample(lat, x1, x2, t, last);
      if ({x1, x2, t, last, lat[3:0]} !== {ei, ~ei, ei[1:0], (j == DEPTH - 1), 4'd2}) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++; $display("FAIL ovf_full_epoch: %0d of 64 serves wrong want 0", bad);
    end
    request_sample(lat, x1, x2, t, last);
    n_vec++;
    if ({x1, x2, t, last} !== {7'h00, 7'h7F, 2'd0, 1'b0}) begin
      n_err++; $display("FAIL ovf_dropped_write: x1=%h x2=%h t=%0d last=%b want 00/7f/0/0",
        x1, x2, t, last);
    end
  endtask

  task automatic test_ignored_requests();
    int seen, served, bad;
    logic [X_W-1:0] ex1;
    do_clear();
    bus_if.requestFlag = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus_if.dataReady) seen++;
    end
    bus_if.requestFlag = 1'b0;
    n_vec++;
    if (seen !== 0 || dbg_state !== LOAD) begin
      n_err++; $display("FAIL ign_load_request: %0d dataReady pulses state=%0d want 0/0",
        seen, dbg_state);
    end
    for (int i = 0; i < 4; i++) write_sample(X_W'(20 + i), X_W'(-i), T_W'(i));
    load_done();
    // Held request: serves at edges 2, 5, 8, ... cycling 0,1,2,3,0,...
    bus_if.requestFlag = 1'b1;
    served = 0;
    bad = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (bus_if.dataReady) begin
        ex1 = X_W'(20 + (served % 4));
        if (c != 2 + 3 * served || bus_if.x1Input !== ex1 ||
            bus_if.lastSample !== ((served % 4) == 3)) bad++;
        served++;
      end
    end
    bus_if.requestFlag = 1'b0;
    n_vec++;
    if (served !== 8 || bad !== 0) begin
      n_err++; $display("FAIL ign_held_request: served=%0d bad=%0d want 8/0", served, bad);
    end
    tick();
    // Host strobes outside LOAD have no effect.
    bus_if.wrEn = 1'b1;
    bus_if.loadDone = 1'b1;
    tick();
    bus_if.wrEn = 1'b0;
    bus_if.loadDone = 1'b0;
    tick();
    n_vec++;
    if (bus_if.nInput !== 32'd4 || dbg_state !== READY || bus_if.overflow !== 1'b0) begin
      n_err++; $display("FAIL ign_host_strobes: nInput=%0d state=%0d ovf=%b want 4/1/0",
        bus_if.nInput, dbg_state, bus_if.overflow);
    end
  endtask

  task automatic test_edge_cases();
    int lat; logic [X_W-1:0] x1, x2; logic [T_W-1:0] t; logic last;
    do_clear();
    load_done();
    n_vec++;
    if (bus_if.emptyErr !== 1'b1 || dbg_state !== LOAD || bus_if.nInput !== 32'd0) begin
      n_err++; $display("FAIL edge_empty_pulse: emptyErr=%b state=%0d nInput=%0d want 1/0/0",
        bus_if.emptyErr, dbg_state, bus_if.nInput);
    end
    tick();
    n_vec++;
    if (bus_if.emptyErr !== 1'b0) begin
      n_err++; $display("FAIL edge_empty_one_cycle: emptyErr=%b want 0", bus_if.emptyErr);
    end
    // Write and loadDone together: the write counts.
    bus_if.wrEn = 1'b1; bus_if.loadDone = 1'b1;
    bus_if.wrX1 = 7'h33; bus_if.wrX2 = 7'h4C; bus_if.wrT = 2'd3;
    tick();
    bus_if.wrEn = 1'b0; bus_if.loadDone = 1'b0;
    n_vec++;
    if (bus_if.nInput !== 32'd1 || dbg_state !== READY || bus_if.emptyErr !== 1'b0) begin
      n_err++; $display("FAIL edge_write_with_load: nInput=%0d state=%0d emptyErr=%b want 1/1/0",
        bus_if.nInput, dbg_state, bus_if.emptyErr);
    end
    request_sample(lat, x1, x2, t, last);
    n_vec++;
    if ({x1, x2, t, last} !== {7'h33, 7'h4C, 2'd3, 1'b1}) begin
      n_err++; $display("FAIL edge_single_sample: x1=%h x2=%h t=%0d last=%b want 33/4c/3/1",
        x1, x2, t, last);
    end
    // clear while in PRESENT.
    bus_if.requestFlag = 1'b1;
    tick();
    bus_if.requestFlag = 1'b0;
    tick();
    bus_if.clear = 1'b1;
    #1;
    n_vec++;
    if (bus_if.dataReady !== 1'b0 || bus_if.lastSample !== 1'b0) begin
      n_err++; $display("FAIL edge_clear_present: dataReady=%b last=%b want 0/0",
        bus_if.dataReady, bus_if.lastSample);
    end
    tick();
    bus_if.clear = 1'b0;
    n_vec++;
    if (bus_if.nInput !== 32'd0 || dbg_state !== LOAD || bus_if.x1Input !== 7'h33) begin
      n_err++; $display("FAIL edge_after_clear: nInput=%0d state=%0d x1=%h want 0/0/33",
        bus_if.nInput, dbg_state, bus_if.x1Input);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic_serve();
    test_wrap();
    test_overflow();
    test_ignored_requests();
    test_edge_cases();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
